// File: rtl/tcp_stream_check.sv
// tcp_stream_check: checks a stream of TCP segments (ports, seq, ack, counting payload).
// Define TCP_CSUM_CHECK_EN to add the ones-complement checksum check (err_code 7).
module tcp_stream_check #(
    parameter logic [15:0] SRC_PORT  = 16'h0400,
    parameter logic [15:0] DES_PORT  = 16'h00aa,
    parameter logic [31:0] SEQ_INIT  = 32'h55bc55bc,
    parameter logic [31:0] ACK_NUM   = 32'hbc55bc55,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tcp_data_in,
    input  logic        tcp_data_valid,
    output logic        seg_done,
    output logic        tcp_error_out,
    output logic [2:0]  err_code,
    output logic [15:0] seg_count,
    output logic [15:0] err_count,
    output logic [31:0] exp_seq
);

    localparam logic [2:0] E_NONE = 3'd0;
    localparam logic [2:0] E_PORT = 3'd1;
    localparam logic [2:0] E_SEQ  = 3'd2;
    localparam logic [2:0] E_ACK  = 3'd3;
    localparam logic [2:0] E_OFF  = 3'd4;
    localparam logic [2:0] E_PAY  = 3'd5;
    localparam logic [2:0] E_LEN  = 3'd6;
`ifdef TCP_CSUM_CHECK_EN
    localparam logic [2:0] E_CSUM = 3'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_OPT,
        S_DATA,
        S_END
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_cnt;
    logic [15:0] r_pay;
    logic [3:0]  r_off;
    logic        r_ctl;
    logic [2:0]  r_err;
    logic [2:0]  r_err_code;
    logic [15:0] r_seg_cnt;
    logic [15:0] r_err_cnt;
    logic [31:0] r_exp_seq;

    logic [3:0]  w_w3_off;
    logic [15:0] w_w3_len;
    logic [15:0] w_w3_pay;
    logic        w_busy;
    logic        w_seg_end;
    logic        w_hdr_last;
    logic        w_opt_last;
    logic        w_trunc;
    logic [2:0]  w_err_now;
    logic [2:0]  w_end_err;
    logic [2:0]  w_final;

    assign w_w3_off   = tcp_data_in[31:28];
    assign w_w3_len   = tcp_data_in[15:0];
    assign w_w3_pay   = (w_w3_len >> 2) - {12'd0, w_w3_off};
    assign w_busy     = (r_state == S_HDR) || (r_state == S_OPT)
                     || (r_state == S_DATA);
    assign w_seg_end  = w_busy && !tcp_data_valid;
    assign w_hdr_last = (r_cnt == 16'd4);
    assign w_opt_last = (r_cnt == ({12'd0, r_off} - 16'd6));
    assign w_trunc    = (r_state == S_HDR) || (r_state == S_OPT)
                     || ((r_state == S_DATA) && (r_cnt < r_pay));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (tcp_data_valid) w_next = S_HDR;
            end
            S_HDR: begin
                if (!tcp_data_valid) w_next = S_END;
                else if (w_hdr_last) w_next = (r_off > 4'd5) ? S_OPT : S_DATA;
            end
            S_OPT: begin
                if (!tcp_data_valid) w_next = S_END;
                else if (w_opt_last) w_next = S_DATA;
            end
            S_DATA: begin
                if (!tcp_data_valid) w_next = S_END;
            end
            S_END: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Error raised by the word being sampled this cycle
    always_comb begin
        w_err_now = E_NONE;
        if (tcp_data_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (tcp_data_in != {SRC_PORT, DES_PORT}) w_err_now = E_PORT;
                end
                S_HDR: begin
                    case (r_cnt)
                        16'd1: if (tcp_data_in != r_exp_seq) w_err_now = E_SEQ;
                        16'd2: if (tcp_data_in != ACK_NUM) w_err_now = E_ACK;
                        16'd3: begin
                            if ((w_w3_off < 4'd5)
                                || ({10'd0, w_w3_off, 2'b00} > w_w3_len))
                                w_err_now = E_OFF;
                            else if ((w_w3_len[1:0] != 2'b00)
                                     || (w_w3_pay > MAX_WORDS))
                                w_err_now = E_LEN;
                        end
                        default: w_err_now = E_NONE;
                    endcase
                end
                S_DATA: begin
                    if (r_cnt >= r_pay) w_err_now = E_LEN;
                    else if (tcp_data_in != {16'd0, r_cnt}) w_err_now = E_PAY;
                end
                default: w_err_now = E_NONE;
            endcase
        end
    end

`ifdef TCP_CSUM_CHECK_EN
    logic [15:0] r_csum;
    logic [15:0] w_csum_base;
    logic [15:0] w_csum_sum;

    function automatic logic [15:0] f_oadd(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[15:0] + {15'd0, t[16]};
    endfunction

    assign w_csum_base = (r_state == S_IDLE) ? 16'd0 : r_csum;
    assign w_csum_sum  = f_oadd(f_oadd(w_csum_base, tcp_data_in[31:16]),
                                tcp_data_in[15:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= 16'd0;
        end else if (tcp_data_valid && ((r_state == S_IDLE) || w_busy)) begin
            r_csum <= w_csum_sum;
        end
    end
`endif

    // Errors only knowable once valid drops
    always_comb begin
        w_end_err = E_NONE;
        if (w_trunc) w_end_err = E_LEN;
`ifdef TCP_CSUM_CHECK_EN
        else if (r_csum != 16'hFFFF) w_end_err = E_CSUM;
`endif
    end

    assign w_final = (r_err != E_NONE) ? r_err : w_end_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= 16'd0;
            r_pay      <= 16'd0;
            r_off      <= 4'd0;
            r_ctl      <= 1'b0;
            r_err      <= E_NONE;
            r_err_code <= E_NONE;
            r_seg_cnt  <= 16'd0;
            r_err_cnt  <= 16'd0;
            r_exp_seq  <= SEQ_INIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tcp_data_valid) begin
                        r_cnt <= 16'd1;
                        r_err <= w_err_now;
                    end
                end
                S_HDR: begin
                    if (tcp_data_valid) begin
                        if (r_cnt == 16'd3) begin
                            r_off <= w_w3_off;
                            r_pay <= w_w3_pay;
                            r_ctl <= |tcp_data_in[17:16];
                        end
                        r_cnt <= w_hdr_last ? 16'd0 : r_cnt + 16'd1;
                    end
                end
                S_OPT: begin
                    if (tcp_data_valid) r_cnt <= w_opt_last ? 16'd0 : r_cnt + 16'd1;
                end
                S_DATA: begin
                    if (tcp_data_valid && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
                end
                default: r_cnt <= r_cnt;
            endcase
            if (w_busy && tcp_data_valid && (r_err == E_NONE)) r_err <= w_err_now;
            if (w_seg_end) begin
                r_err_code <= w_final;
                if (r_seg_cnt != 16'hFFFF) r_seg_cnt <= r_seg_cnt + 16'd1;
                if (w_final != E_NONE) begin
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                end else begin
                    r_exp_seq <= r_exp_seq + {14'd0, r_pay, 2'b00} + {31'd0, r_ctl};
                end
            end
        end
    end

    always_comb begin
        seg_done      = (r_state == S_END);
        tcp_error_out = (r_state == S_END) && (r_err_code != E_NONE);
    end

    assign err_code  = r_err_code;
    assign seg_count = r_seg_cnt;
    assign err_count = r_err_cnt;
    assign exp_seq   = r_exp_seq;

endmodule

// File: tb/tb_tcp_stream_check.sv
// Self-checking bench for tcp_stream_check: builds segments, queues expected
// outcomes, and compares them when seg_done fires.
module tb_tcp_stream_check;

    localparam logic [15:0] SRC  = 16'h0400;
    localparam logic [15:0] DST  = 16'h00aa;
    localparam logic [31:0] SEQ0 = 32'h55bc55bc;
    localparam logic [31:0] ACK  = 32'hbc55bc55;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tcp_data_in = 32'd0;
    logic        tcp_data_valid = 1'b0;
    logic        seg_done;
    logic        tcp_error_out;
    logic [2:0]  err_code;
    logic [15:0] seg_count;
    logic [15:0] err_count;
    logic [31:0] exp_seq;

    always #5 clk = ~clk;

    tcp_stream_check dut (
        .clk            (clk),
        .reset          (reset),
        .tcp_data_in    (tcp_data_in),
        .tcp_data_valid (tcp_data_valid),
        .seg_done       (seg_done),
        .tcp_error_out  (tcp_error_out),
        .err_code       (err_code),
        .seg_count      (seg_count),
        .err_count      (err_count),
        .exp_seq        (exp_seq)
    );

    typedef struct packed {
        logic [2:0]  code;
        logic [15:0] segs;
        logic [15:0] errs;
        logic [31:0] seq;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] seg[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_seq = SEQ0;
    logic [15:0] m_segs = 16'd0;
    logic [15:0] m_errs = 16'd0;

    function automatic logic [15:0] oadd(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[15:0] + {15'd0, t[16]};
    endfunction

    task automatic build(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [3:0] off,
                         input logic [15:0] len, input logic [7:0] flags,
                         input int nopt, input int npay);
        logic [15:0] s;
        s = 16'd0;
        seg.delete();
        seg.push_back(w0);
        seg.push_back(w1);
        seg.push_back(w2);
        seg.push_back({off, 4'h0, flags, len});
        seg.push_back(32'd0);
        for (int i = 0; i < nopt; i++) seg.push_back({16'hc0de, 16'(i)});
        for (int i = 0; i < npay; i++) seg.push_back(32'(i));
        foreach (seg[j]) s = oadd(oadd(s, seg[j][31:16]), seg[j][15:0]);
        seg[4] = {~s, 16'h0000};
    endtask

    task automatic push_exp(input logic [2:0] code, input logic [31:0] adv);
        if (m_segs != 16'hFFFF) m_segs = m_segs + 16'd1;
        if (code != 3'd0) m_errs = m_errs + 16'd1;
        else m_seq = m_seq + adv;
        sb.push_back('{code, m_segs, m_errs, m_seq});
    endtask

    task automatic send_seg(input int nsend, output bit got);
        for (int i = 0; i < nsend; i++) begin
            @(posedge clk);
            #1;
            tcp_data_valid = 1'b1;
            tcp_data_in = seg[i];
        end
        @(posedge clk);
        #1;
        tcp_data_valid = 1'b0;
        tcp_data_in = 32'd0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (seg_done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (seg_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", seg_done); end
        n_cmp++; if (tcp_error_out !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", tcp_error_out); end
        n_cmp++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL rst_code: got %0d want 0", err_code); end
        n_cmp++; if (seg_count !== 16'd0) begin n_bad++; $display("FAIL rst_segs: got %0d want 0", seg_count); end
        n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL rst_errs: got %0d want 0", err_count); end
        n_cmp++; if (exp_seq !== SEQ0) begin n_bad++; $display("FAIL rst_seq: got %h want %h", exp_seq, SEQ0); end
    endtask

    task automatic test_good();
        bit got;
        exp_t e;
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd28, 8'h10, 0, 2);
        push_exp(3'd0, 32'd8);
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL good_done: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL good_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (tcp_error_out !== 1'b0) begin n_bad++; $display("FAIL good_err: got %b want 0", tcp_error_out); end
        n_cmp++; if (exp_seq !== SEQ0 + 32'd8) begin n_bad++; $display("FAIL good_seq: got %h want %h", exp_seq, SEQ0 + 32'd8); end
        n_cmp++; if (seg_count !== e.segs) begin n_bad++; $display("FAIL good_segs: got %0d want %0d", seg_count, e.segs); end
    endtask

    task automatic test_port();
        bit got;
        exp_t e;
        build(32'h04010aa0, m_seq, ACK, 4'd5, 16'd28, 8'h10, 0, 2);
        push_exp(3'd1, 32'd0);
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL port_done: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL port_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (tcp_error_out !== 1'b1) begin n_bad++; $display("FAIL port_err: got %b want 1", tcp_error_out); end
        n_cmp++; if (err_count !== e.errs) begin n_bad++; $display("FAIL port_errs: got %0d want %0d", err_count, e.errs); end
        n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL port_seq: got %h want %h", exp_seq, e.seq); end
    endtask

    task automatic test_options();
        bit got;
        exp_t e;
        build({SRC, DST}, m_seq, ACK, 4'd7, 16'd44, 8'h18, 2, 4);
        push_exp(3'd0, 32'd16);
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL opt_done: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL opt_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL opt_seq: got %h want %h", exp_seq, e.seq); end
        @(negedge clk);
        n_cmp++; if (seg_done !== 1'b0) begin n_bad++; $display("FAIL opt_pulse: got %b want 0", seg_done); end
    endtask

    task automatic test_first_error();
        bit got;
        exp_t e;
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd44, 8'h10, 0, 6);
        seg[7] = 32'd5;
        push_exp(3'd5, 32'd0);
        send_seg(9, got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL first_done: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL first_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (tcp_error_out !== 1'b1) begin n_bad++; $display("FAIL first_err: got %b want 1", tcp_error_out); end
        n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL first_seq: got %h want %h", exp_seq, e.seq); end
        @(negedge clk);
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL first_hold: got %0d want %0d", err_code, e.code); end
    endtask

    task automatic test_syn();
        bit got;
        exp_t e;
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd20, 8'h02, 0, 0);
        push_exp(3'd0, 32'd1);
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL syn_done: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL syn_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL syn_seq: got %h want %h", exp_seq, e.seq); end
    endtask

    task automatic test_csum();
        bit got;
        exp_t e;
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd28, 8'h10, 0, 2);
        seg[4] = seg[4] ^ 32'h0100_0000;
`ifdef TCP_CSUM_CHECK_EN
        push_exp(3'd7, 32'd0);
`else
        push_exp(3'd0, 32'd8);
`endif
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL csum_done: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL csum_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL csum_seq: got %h want %h", exp_seq, e.seq); end
    endtask

    task automatic test_max_words();
        bit got;
        exp_t e;
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd4116, 8'h10, 0, 1024);
        push_exp(3'd0, 32'd4096);
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL max_done: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL max_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL max_seq: got %h want %h", exp_seq, e.seq); end
    endtask

    task automatic test_errors();
        bit got;
        exp_t e;
        logic [31:0] w0, w1, w2;
        logic [3:0]  off;
        logic [15:0] len;
        logic [2:0]  want;
        int nopt, npay, nsend;
        for (int k = 0; k < 9; k++) begin
            w0 = {SRC, DST}; w1 = m_seq; w2 = ACK;
            off = 4'd5; len = 16'd28; nopt = 0; npay = 2; nsend = -1;
            case (k)
                0: begin w1 = m_seq + 32'd1; want = 3'd2; end
                1: begin w2 = ACK ^ 32'd1; want = 3'd3; end
                2: begin off = 4'd4; want = 3'd4; end
                3: begin len = 16'd30; want = 3'd6; end
                4: begin npay = 3; want = 3'd6; end
                5: begin len = 16'd4120; want = 3'd6; end
                6: begin nsend = 3; want = 3'd6; end
                7: begin off = 4'd6; len = 16'd20; nopt = 1; npay = 0; want = 3'd4; end
                default: begin w0 = {SRC, DST} ^ 32'd1; w1 = m_seq + 32'd7; want = 3'd1; end
            endcase
            build(w0, w1, w2, off, len, 8'h10, nopt, npay);
            if (nsend < 0) nsend = seg.size();
            push_exp(want, 32'd0);
            send_seg(nsend, got);
            e = sb.pop_front();
            n_cmp++; if (!got) begin n_bad++; $display("FAIL err%0d_done: seg_done not seen, want pulse", k); end
            n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL err%0d_code: got %0d want %0d", k, err_code, e.code); end
            n_cmp++; if (tcp_error_out !== 1'b1) begin n_bad++; $display("FAIL err%0d_flag: got %b want 1", k, tcp_error_out); end
            n_cmp++; if (err_count !== e.errs) begin n_bad++; $display("FAIL err%0d_errs: got %0d want %0d", k, err_count, e.errs); end
            n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL err%0d_seq: got %h want %h", k, exp_seq, e.seq); end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd36, 8'h10, 0, 4);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            tcp_data_valid = 1'b1;
            tcp_data_in = seg[i];
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        tcp_data_valid = 1'b0;
        tcp_data_in = 32'd0;
        #1;
        n_cmp++; if (seg_done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", seg_done); end
        n_cmp++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL mid_code: got %0d want 0", err_code); end
        n_cmp++; if (seg_count !== 16'd0) begin n_bad++; $display("FAIL mid_segs: got %0d want 0", seg_count); end
        n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL mid_errs: got %0d want 0", err_count); end
        n_cmp++; if (exp_seq !== SEQ0) begin n_bad++; $display("FAIL mid_seq: got %h want %h", exp_seq, SEQ0); end
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        m_seq = SEQ0; m_segs = 16'd0; m_errs = 16'd0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (seg_done) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_pulse: got %0d want 0", pulses); end
        n_cmp++; if (seg_count !== 16'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", seg_count); end
    endtask

    task automatic test_back_to_back();
        bit got;
        exp_t e;
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd28, 8'h10, 0, 2);
        push_exp(3'd0, 32'd8);
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL b2b_done0: seg_done not seen, want pulse"); end
        n_cmp++; if (seg_count !== e.segs) begin n_bad++; $display("FAIL b2b_segs0: got %0d want %0d", seg_count, e.segs); end
        build({SRC, DST}, m_seq, ACK, 4'd5, 16'd24, 8'h11, 0, 1);
        push_exp(3'd0, 32'd5);
        send_seg(seg.size(), got);
        e = sb.pop_front();
        n_cmp++; if (!got) begin n_bad++; $display("FAIL b2b_done1: seg_done not seen, want pulse"); end
        n_cmp++; if (err_code !== e.code) begin n_bad++; $display("FAIL b2b_code: got %0d want %0d", err_code, e.code); end
        n_cmp++; if (seg_count !== e.segs) begin n_bad++; $display("FAIL b2b_segs1: got %0d want %0d", seg_count, e.segs); end
        n_cmp++; if (exp_seq !== e.seq) begin n_bad++; $display("FAIL b2b_seq: got %h want %h", exp_seq, e.seq); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good();
        test_port();
        test_options();
        test_first_error();
        test_syn();
        test_csum();
        test_max_words();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcp_stream_check.md
TCP_STREAM_CHECK -- requirements
Module: tcp_stream_check

Interface
REQ-001 SHALL have parameter SRC_PORT, default 16'h0400, expected source port.
REQ-002 SHALL have parameter DES_PORT, default 16'h00aa, expected destination port.
REQ-003 SHALL have parameter SEQ_INIT, default 32'h55bc55bc, expected sequence number of the first segment after reset.
REQ-004 SHALL have parameter ACK_NUM, default 32'hbc55bc55, expected acknowledgement number for every segment.
REQ-005 SHALL have parameter MAX_WORDS, default 16'd1024, maximum payload words per segment.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port tcp_data_in, input, 32, segment word.
REQ-009 SHALL have port tcp_data_valid, input, 1, word qualifier; high contiguously for one segment.
REQ-010 SHALL have port seg_done, output, 1, one-cycle pulse at segment end.
REQ-011 SHALL have port tcp_error_out, output, 1, high with seg_done when the segment failed.
REQ-012 SHALL have port err_code, output, 3, first error of the last segment; held until the next seg_done.
REQ-013 SHALL have port seg_count, output, 16, segments checked; saturates at 16'hFFFF.
REQ-014 SHALL have port err_count, output, 16, failed segments; saturates at 16'hFFFF.
REQ-015 SHALL have port exp_seq, output, 32, currently expected sequence number.

Function
REQ-016 SHALL use this segment format: W0={src,dst}; W1=seq; W2=ack; W3={offset[31:28],rsvd[27:24],flags[23:16],len_bytes[15:0]}; W4={checksum,urg_ptr}; then (offset-5) option words, skipped; then payload words.
REQ-017 SHALL use states IDLE, HDR, OPT, DATA, END: IDLE->HDR when valid is sampled high; HDR->OPT after W4 if offset>5, else ->DATA; OPT->DATA after the last option word; any non-IDLE state->END when valid is sampled low; END->IDLE unconditionally.
REQ-018 SHALL sample W0 in the same edge that leaves IDLE, with zero input pipeline.
REQ-019 SHALL compute payload words as (len_bytes>>2)-offset, 16-bit unsigned.
REQ-020 SHALL expect payload word k (0-based) to equal k zero-extended to 32 bits.
REQ-021 SHALL use err_code values: 0 none, 1 port, 2 seq, 3 ack, 4 offset (<5, or 4*offset>len_bytes), 5 payload mismatch, 6 length (len_bytes[1:0]!=0, payload>MAX_WORDS, truncated, or words beyond length), 7 checksum.
REQ-022 SHALL record only the earliest error of a segment; later errors SHALL NOT overwrite it.
REQ-023 SHALL assert seg_done, tcp_error_out, err_code and the counters in END, one cycle after the edge that samples valid low.
REQ-024 SHALL, on an error-free segment, advance exp_seq by 4*payload words, plus 1 if flags[1] (SYN) or flags[0] (FIN) is set, modulo 2^32.
REQ-025 SHALL leave exp_seq unchanged on a failed segment.
REQ-026 SHALL accept a zero-payload segment with nonzero flags as a valid control segment.
REQ-027 SHALL ignore tcp_data_valid while in END; a new segment requires at least one low cycle.

Reset
REQ-028 SHALL, on reset assertion at any time, including mid-segment, immediately force state IDLE; seg_done, tcp_error_out=0; err_code=0; counts=0; exp_seq=SEQ_INIT.
REQ-029 SHALL discard a partial segment interrupted by reset and SHALL NOT count it.

Configuration
REQ-030 SHALL, with TCP_CSUM_CHECK_EN defined, sum all 16-bit halves of the segment, ones-complement with end-around carry, and flag code 7 if the result is not 16'hFFFF.
REQ-031 SHALL, without TCP_CSUM_CHECK_EN, omit the checksum logic; code 7 is never produced and the checksum field is ignored.

Verification
REQ-032 SHALL cover: a good segment with offset 5, len 28, payload 0,1 -> seg_done, error 0, exp_seq=SEQ_INIT+8, seg_count=1.
REQ-033 SHALL cover: W0=32'h04010aa0 -> err_code 1, err_count=1, exp_seq unchanged.
REQ-034 SHALL cover: offset 7 with 2 option words, payload 0..3 -> options skipped, pass, exp_seq +16.
REQ-035 SHALL cover: payload word 2 = 5 followed by an early valid drop -> err_code 5 (first error kept), tcp_error_out high.
REQ-036 SHALL cover: a SYN segment with zero payload -> pass, exp_seq +1; then reset mid-payload -> outputs zero, seg_count unchanged.
REQ-037 SHALL cover: with TCP_CSUM_CHECK_EN, a corrupted checksum -> err_code 7; without the macro, the same stimulus passes.
